// File: rtl/result_bcd_converter.sv
// Sequential two's-complement to sign + 6-digit packed BCD converter (double dabble),
// one result bit per clock, valid/ready handshake on input and output.
module result_bcd_converter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        negative,
  output logic [23:0] bcd
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [17:0] r_mag;
  logic [23:0] r_bcd_sh;
  logic [4:0]  r_cnt;
  logic        r_sign;
  logic [23:0] r_bcd;
  logic        r_neg;
  logic [23:0] w_bcd_adj;
  logic        w_last;

  assign w_last = (r_cnt == 5'd18);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (in_valid)  w_state_next = StShift;
      StShift: if (w_last)    w_state_next = StDone;
      StDone:  if (out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Handshake outputs depend on registered state only
  always_comb begin
    in_ready  = (r_state == StIdle);
    out_valid = (r_state == StDone);
  end

  // Add-3 correction on every digit before the shift
  always_comb begin
    w_bcd_adj = r_bcd_sh;
    for (int i = 0; i < 6; i++) begin
      if (r_bcd_sh[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd_sh[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mag    <= '0;
      r_bcd_sh <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_bcd    <= '0;
      r_neg    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_sign   <= result[17];
            r_mag    <= result[17] ? (~result + 18'd1) : result;
            r_bcd_sh <= '0;
            r_cnt    <= '0;
          end
        end
        StShift: begin
          if (w_last) begin
            r_bcd <= r_bcd_sh;
            r_neg <= r_sign;
          end else begin
            {r_bcd_sh, r_mag} <= {w_bcd_adj, r_mag} << 1;
            r_cnt             <= r_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign negative = r_neg;
  assign bcd      = r_bcd;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Scoreboard bench for result_bcd_converter: driver pushes expected results on accept,
// a negedge monitor checks handshake timing, output stability and popped results.
module tb_result_bcd_converter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [17:0] result = '0;
  logic        in_ready;
  logic        out_valid;
  logic        negative;
  logic [23:0] bcd;

  always #5 clk = ~clk;

  result_bcd_converter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .negative  (negative),
    .bcd       (bcd)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [24:0] sb_q[$];
  logic [24:0] pend_exp = '0;
  logic [24:0] exp_out = '0;
  bit          busy = 1'b0;
  int          acc_e0 = 0;
  int          last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: sign flag plus decimal digits of the magnitude, by plain arithmetic
  function automatic logic [24:0] model(input logic [17:0] v);
    int unsigned m;
    logic [23:0] b;
    m = v[17] ? (32'd262144 - 32'(v)) : 32'(v);
    b = '0;
    for (int i = 0; i < 6; i++) begin
      b[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {v[17], b};
  endfunction

  // Monitor: expected behaviour derived from accept time and handshake only
  always @(negedge clk) begin : mon
    logic exp_ov;
    if (reset_n === 1'b1) begin
      exp_ov = busy && (cyc >= acc_e0 + 19);
      if (busy && cyc == acc_e0 + 19 && sb_q.size() > 0) exp_out = sb_q[0];
      chk("in_ready", 32'(in_ready), 32'(!busy));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("outputs_held", 32'({negative, bcd}), 32'(exp_out));
      if (in_valid && !busy) begin
        sb_q.push_back(pend_exp);
        acc_e0   = cyc + 1;
        last_acc = cyc + 1;
        busy     = 1'b1;
      end else if (exp_ov && out_ready) begin
        if (sb_q.size() > 0) chk("scoreboard", 32'({negative, bcd}), 32'(sb_q.pop_front()));
        busy = 1'b0;
      end
    end
  end

  task automatic wait_busy(input bit want, input string name);
    int n = 0;
    while (busy != want && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (busy != want) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout, busy=%0d required %0d", name, busy, want);
    end
  endtask

  task automatic send(input logic [17:0] v, input logic [24:0] exp, input int hold);
    wait_busy(1'b0, "idle_before_send");
    @(posedge clk);
    #2;
    pend_exp  = exp;
    result    = v;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    wait_busy(1'b1, "accept");
    #2;
    in_valid = 1'b0;
    result   = 18'($urandom);
    if (hold > 0) begin
      repeat (19) @(posedge clk);
      for (int i = 0; i < hold; i++) begin
        #2;
        in_valid = i[0];
        result   = 18'($urandom);
        @(posedge clk);
      end
      #2;
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    wait_busy(1'b0, "release");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a1;
    int a2;
    logic [17:0] rv;
    reset_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_negative", 32'(negative), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;

    send(18'd510,    {1'b0, 24'h000510}, 0);
    send(18'h3FFFE,  {1'b1, 24'h000002}, 0);
    send(18'h3FF01,  {1'b1, 24'h000255}, 1);
    send(18'h20000,  {1'b1, 24'h131072}, 0);
    send(18'h1FFFF,  {1'b0, 24'h131071}, 2);
    send(18'h0,      {1'b0, 24'h000000}, 0);
    send(18'd99999,  {1'b0, 24'h099999}, 10);

    // Abort after the 7th shift; outputs must clear asynchronously
    wait_busy(1'b0, "idle_before_reset");
    @(posedge clk);
    #2;
    pend_exp  = {1'b0, 24'h000510};
    result    = 18'd510;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    wait_busy(1'b1, "accept_reset_case");
    #2;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_bcd", 32'(bcd), 32'd0);
    chk("async_rst_negative", 32'(negative), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    sb_q.delete();
    busy    = 1'b0;
    exp_out = '0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    send(18'd42, {1'b0, 24'h000042}, 0);

    // Back-to-back with in_valid and out_ready held high
    wait_busy(1'b0, "idle_before_b2b");
    @(posedge clk);
    #2;
    pend_exp  = {1'b0, 24'h000007};
    result    = 18'd7;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    wait_busy(1'b1, "b2b_accept1");
    a1 = last_acc;
    #2;
    pend_exp = {1'b1, 24'h000007};
    result   = 18'h3FFF9;
    for (int n = 0; n < 40 && last_acc == a1; n++) @(posedge clk);
    a2 = last_acc;
    #2;
    in_valid = 1'b0;
    chk("b2b_accept_gap", 32'(a2 - a1), 32'd21);
    wait_busy(1'b0, "b2b_release");

    for (int k = 0; k < 30; k++) begin
      rv = 18'($urandom);
      send(rv, model(rv), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
